// File: rtl/constraint_sampler.sv
// Purpose: seeded LFSR candidate generator that feeds a combinational constraint
//          checker and streams the candidates it accepts downstream.
// Latency: first CHECK WORDS+1 cycles after start; first solution valid at WORDS+2.
// Backpressure: solution and candidate are held until sol_ready_i; nothing is generated while held.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start_i           begin a run (honoured only when idle)
//   num_req_i         number of solutions requested, latched at start
//   seed_i            LFSR seed, latched at start (0 is replaced by 1)
//   cand_o            registered candidate vector driven to the checker
//   sat_i             checker verdict for the current cand_o
//   sol_valid_o       accepted solution is available
//   sol_ready_i       downstream takes the solution
//   sol_data_o        accepted solution (same bits as cand_o while valid)
//   busy_o            run in progress
//   done_o / fail_o   sticky run outcome, cleared by the next start
//   tries_o           saturating count of candidates checked in the run
module constraint_sampler #(
    parameter int VEC_W     = 185,
    parameter int MAX_TRIES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [15:0]      num_req_i,
    input  logic [31:0]      seed_i,
    output logic [VEC_W-1:0] cand_o,
    input  logic             sat_i,
    output logic             sol_valid_o,
    input  logic             sol_ready_i,
    output logic [VEC_W-1:0] sol_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [31:0]      tries_o
);

    localparam int WORDS  = (VEC_W + 31) / 32;
    localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam logic [31:0] LFSR_MASK = 32'hA300_0000;

    // S_ZERO is the single busy cycle taken when a run asks for no solutions.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ZERO  = 3'd1,
        S_FILL  = 3'd2,
        S_CHECK = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         lfsr_q,  lfsr_d;
    logic [VEC_W-1:0]    cand_q,  cand_d;
    logic [WCNT_W-1:0]   word_q,  word_d;
    logic [TRY_W-1:0]    try_q,   try_d;
    logic [31:0]         tries_q, tries_d;
    logic [15:0]         sol_q,   sol_d;
    logic [15:0]         num_q,   num_d;
    logic                done_q,  done_d;
    logic                fail_q,  fail_d;

    logic [31:0]         lfsr_next;
    logic [VEC_W+31:0]   shifted;
    logic [TRY_W-1:0]    try_inc;
    logic [15:0]         sol_inc;

    // Right-shift Galois step; only used while filling.
    always_comb begin
        lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cand_d  = cand_q;
        word_d  = word_q;
        try_d   = try_q;
        tries_d = tries_q;
        sol_d   = sol_q;
        num_d   = num_q;
        done_d  = done_q;
        fail_d  = fail_q;
        // New LFSR word enters the LSBs; oldest bits fall off the top.
        shifted = {cand_q, lfsr_q};
        try_inc = try_q + 1'b1;
        sol_inc = sol_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lfsr_d  = (seed_i == 32'd0) ? 32'd1 : seed_i;
                    cand_d  = '0;
                    word_d  = '0;
                    try_d   = '0;
                    tries_d = '0;
                    sol_d   = '0;
                    num_d   = num_req_i;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    if (num_req_i == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = S_ZERO;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end

            S_ZERO: begin
                state_d = S_IDLE;
            end

            S_FILL: begin
                cand_d = shifted[VEC_W-1:0];
                lfsr_d = lfsr_next;
                if (word_q == WCNT_W'(WORDS - 1)) begin
                    word_d  = '0;
                    state_d = S_CHECK;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end

            S_CHECK: begin
                try_d = try_inc;
                if (tries_q != 32'hFFFF_FFFF) begin
                    tries_d = tries_q + 32'd1;
                end
                if (sat_i) begin
                    state_d = S_EMIT;
                end else if (try_inc == TRY_W'(MAX_TRIES)) begin
                    fail_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FILL;
                end
            end

            S_EMIT: begin
                // cand_q is untouched here, so data stays stable while stalled.
                if (sol_ready_i) begin
                    sol_d = sol_inc;
                    try_d = '0;
                    if (sol_inc == num_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= 32'd1;
            cand_q  <= '0;
            word_q  <= '0;
            try_q   <= '0;
            tries_q <= '0;
            sol_q   <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cand_q  <= cand_d;
            word_q  <= word_d;
            try_q   <= try_d;
            tries_q <= tries_d;
            sol_q   <= sol_d;
            num_q   <= num_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    assign cand_o      = cand_q;
    assign sol_data_o  = cand_q;
    assign sol_valid_o = (state_q == S_EMIT);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign tries_o     = tries_q;

endmodule

// File: tb/tb_constraint_sampler.sv
module tb_constraint_sampler;

    localparam int VEC_W     = 185;
    localparam int MAX_TRIES = 4;
    localparam int WORDS     = (VEC_W + 31) / 32;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [15:0]      num_req_i;
    logic [31:0]      seed_i;
    logic [VEC_W-1:0] cand_o;
    logic             sat_i;
    logic             sol_valid_o;
    logic             sol_ready_i;
    logic [VEC_W-1:0] sol_data_o;
    logic             busy_o;
    logic             done_o;
    logic             fail_o;
    logic [31:0]      tries_o;

    int checks = 0;
    int errors = 0;

    logic [VEC_W-1:0] exp_q[$];
    logic [VEC_W-1:0] first_sol_seed1;

    constraint_sampler #(.VEC_W(VEC_W), .MAX_TRIES(MAX_TRIES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .num_req_i   (num_req_i),
        .seed_i      (seed_i),
        .cand_o      (cand_o),
        .sat_i       (sat_i),
        .sol_valid_o (sol_valid_o),
        .sol_ready_i (sol_ready_i),
        .sol_data_o  (sol_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fail_o      (fail_o),
        .tries_o     (tries_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference generator: each candidate is WORDS consecutive LFSR states,
    // earliest state ending up in the most significant (truncated) word.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'hA300_0000) : (l >> 1);
    endfunction

    task automatic build_expected(input logic [31:0] seed, input int n);
        logic [31:0]      l;
        logic [VEC_W-1:0] c;
        l = (seed == 32'd0) ? 32'd1 : seed;
        c = '0;
        for (int s = 0; s < n; s++) begin
            for (int w = 0; w < WORDS; w++) begin
                c = (c << 32) | VEC_W'(l);
                l = lfsr_step(l);
            end
            exp_q.push_back(c);
        end
    endtask

    // Per-cycle scoreboard: every presented solution must match the model and
    // must stay put until it is taken.
    logic             prev_vld;
    logic             prev_rdy;
    logic [VEC_W-1:0] prev_dat;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
            prev_dat = '0;
        end else begin
            chk("done_fail_exclusive", VEC_W'(done_o & fail_o), '0);
            if (prev_vld && !prev_rdy) begin
                chk("valid_held", VEC_W'(sol_valid_o), VEC_W'(1));
                chk("data_held", sol_data_o, prev_dat);
            end
            if (sol_valid_o) begin
                chk("data_eq_cand", sol_data_o, cand_o);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid with data %h required no solution", sol_data_o);
                end else begin
                    chk("sol_vs_model", sol_data_o, exp_q[0]);
                    if (sol_ready_i) void'(exp_q.pop_front());
                end
            end
            prev_vld = sol_valid_o;
            prev_rdy = sol_ready_i;
            prev_dat = sol_data_o;
        end
    end

    // Start edge is the posedge inside this task; returns just after it.
    task automatic do_start(input logic [31:0] seed, input logic [15:0] n);
        @(posedge clk);
        #2;
        start_i   = 1'b1;
        seed_i    = seed;
        num_req_i = n;
        @(posedge clk);
        #2;
        start_i   = 1'b0;
        seed_i    = 32'h5555_AAAA;
        num_req_i = 16'd9;
    endtask

    task automatic wait_valid(output int k, input int lim);
        k = 0;
        while (k < lim) begin
            @(negedge clk);
            k++;
            if (sol_valid_o) break;
        end
        if (!sol_valid_o) begin
            checks++;
            errors++;
            $display("FAIL wait_valid_timeout: got no valid in %0d cycles required valid", lim);
        end
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (k < lim && !done_o) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done", VEC_W'(done_o), VEC_W'(1));
    endtask

    initial begin
        int k;
        int busy_cnt;
        int vld_cnt;
        int fail_k;
        int vcyc[$];
        logic [VEC_W-1:0] d0;
        logic [VEC_W-1:0] c0;

        rst_n       = 1'b0;
        start_i     = 1'b0;
        num_req_i   = '0;
        seed_i      = '0;
        sat_i       = 1'b0;
        sol_ready_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", VEC_W'(sol_valid_o), '0);
        chk("rst_busy",  VEC_W'(busy_o), '0);
        chk("rst_done",  VEC_W'(done_o), '0);
        chk("rst_fail",  VEC_W'(fail_o), '0);
        chk("rst_tries", VEC_W'(tries_o), '0);
        chk("rst_cand",  cand_o, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // num_req = 0: one busy cycle, immediately done
        do_start(32'h5, 16'd0);
        busy_cnt = 0;
        vld_cnt  = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            busy_cnt += int'(busy_o);
            vld_cnt  += int'(sol_valid_o);
        end
        chk("zero_busy_cycles", VEC_W'(busy_cnt), VEC_W'(1));
        chk("zero_valids",      VEC_W'(vld_cnt), '0);
        chk("zero_done",        VEC_W'(done_o), VEC_W'(1));
        chk("zero_tries",       VEC_W'(tries_o), '0);

        // Run A: seed 1, always satisfied, always ready, three solutions
        sat_i = 1'b1;
        sol_ready_i = 1'b1;
        build_expected(32'h1, 3);
        do_start(32'h1, 16'd3);
        first_sol_seed1 = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (sol_valid_o) begin
                vcyc.push_back(i);
                if (vcyc.size() == 1) first_sol_seed1 = sol_data_o;
            end
        end
        chk("a_valid_count", VEC_W'(vcyc.size()), VEC_W'(3));
        if (vcyc.size() == 3) begin
            chk("a_valid_cyc0", VEC_W'(vcyc[0]), VEC_W'(8));
            chk("a_valid_cyc1", VEC_W'(vcyc[1]), VEC_W'(16));
            chk("a_valid_cyc2", VEC_W'(vcyc[2]), VEC_W'(24));
        end
        chk("a_word_lo",  VEC_W'(first_sol_seed1[31:0]),   VEC_W'(32'h0A30_0000));
        chk("a_word_1",   VEC_W'(first_sol_seed1[63:32]),  VEC_W'(32'h1460_0000));
        chk("a_word_4",   VEC_W'(first_sol_seed1[159:128]), VEC_W'(32'hA300_0000));
        chk("a_word_top", VEC_W'(first_sol_seed1[184:160]), VEC_W'(25'h1));
        chk("a_done",     VEC_W'(done_o), VEC_W'(1));
        chk("a_fail",     VEC_W'(fail_o), '0);
        chk("a_busy",     VEC_W'(busy_o), '0);
        chk("a_tries",    VEC_W'(tries_o), VEC_W'(3));
        chk("a_model_drained", VEC_W'(exp_q.size()), '0);

        // Never satisfied: fails after MAX_TRIES checks, 4th CHECK at cycle 28
        sat_i = 1'b0;
        do_start(32'h7, 16'd2);
        fail_k  = 0;
        vld_cnt = 0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (fail_o && fail_k == 0) fail_k = i;
            vld_cnt += int'(sol_valid_o);
        end
        chk("f_fail_cycle", VEC_W'(fail_k), VEC_W'(29));
        chk("f_fail",       VEC_W'(fail_o), VEC_W'(1));
        chk("f_done",       VEC_W'(done_o), '0);
        chk("f_tries",      VEC_W'(tries_o), VEC_W'(4));
        chk("f_valids",     VEC_W'(vld_cnt), '0);

        // Backpressure: ready low for 5 cycles of valid, taken on the 6th
        sat_i = 1'b1;
        sol_ready_i = 1'b0;
        build_expected(32'h1, 1);
        do_start(32'h1, 16'd1);
        wait_valid(k, 20);
        chk("bp_first_valid_cyc", VEC_W'(k), VEC_W'(8));
        d0 = sol_data_o;
        c0 = cand_o;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("bp_valid", VEC_W'(sol_valid_o), VEC_W'(1));
            chk("bp_data",  sol_data_o, d0);
            chk("bp_cand",  cand_o, c0);
        end
        @(posedge clk);
        #2;
        sol_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_valid6", VEC_W'(sol_valid_o), VEC_W'(1));
        chk("bp_data6",  sol_data_o, d0);
        @(negedge clk);
        chk("bp_valid_drop", VEC_W'(sol_valid_o), '0);
        chk("bp_done",       VEC_W'(done_o), VEC_W'(1));
        chk("bp_tries",      VEC_W'(tries_o), VEC_W'(1));
        chk("bp_model_drained", VEC_W'(exp_q.size()), '0);

        // Seed 0 behaves as seed 1
        build_expected(32'h1, 3);
        do_start(32'h0, 16'd3);
        wait_done(40);
        chk("s0_model_drained", VEC_W'(exp_q.size()), '0);
        chk("s0_tries", VEC_W'(tries_o), VEC_W'(3));

        // A different seed gives a different first word
        build_expected(32'hDEAD_BEEF, 1);
        do_start(32'hDEAD_BEEF, 16'd1);
        wait_valid(k, 20);
        chk("db_word_top", VEC_W'(sol_data_o[184:160]), VEC_W'(25'h0AD_BEEF));
        checks++;
        if (sol_data_o === first_sol_seed1) begin
            errors++;
            $display("FAIL db_differs: got %h required a value other than the seed-1 solution", sol_data_o);
        end
        wait_done(20);

        // Reset during a stalled EMIT, then replay
        sol_ready_i = 1'b0;
        build_expected(32'h1, 3);
        do_start(32'h1, 16'd3);
        wait_valid(k, 20);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", VEC_W'(sol_valid_o), '0);
        chk("mr_busy",  VEC_W'(busy_o), '0);
        chk("mr_done",  VEC_W'(done_o), '0);
        chk("mr_fail",  VEC_W'(fail_o), '0);
        chk("mr_tries", VEC_W'(tries_o), '0);
        chk("mr_cand",  cand_o, '0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        sol_ready_i = 1'b1;
        build_expected(32'h1, 1);
        do_start(32'h1, 16'd1);
        wait_valid(k, 20);
        chk("mr_replay", sol_data_o, first_sol_seed1);
        chk("mr_replay_lo", VEC_W'(sol_data_o[31:0]), VEC_W'(32'h0A30_0000));
        wait_done(20);
        chk("mr_tries_after", VEC_W'(tries_o), VEC_W'(1));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/constraint_sampler.md
Name: constraint_sampler

Overview:
- Sequential stimulus-side partner for the generated combinational constraint checkers.
- Produces pseudo-random candidate assignments from a seeded LFSR and drives them on a flat vector to a checker's concatenated var inputs.
- Samples the checker's single satisfied flag and streams accepted assignments downstream over a valid/ready handshake.
- Stops after a requested number of solutions, or flags failure when one solution exceeds its try budget.

Parameters:
VEC_W, 185, candidate vector width; the sum of the checker's var widths, var_0 in the LSBs.
MAX_TRIES, 1024, maximum candidates checked per solution before failing; must be >= 1.
WORDS, ceil(VEC_W/32), derived localparam: fill cycles per candidate.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  begin a run; honoured only in IDLE
num_req_i  input  16  solutions requested; sampled at start
seed_i  input  32  LFSR seed; sampled at start; 0 is replaced by 32'h1
cand_o  output  VEC_W  registered candidate driven to the checker
sat_i  input  1  checker result for the current cand_o (combinational from cand_o)
sol_valid_o  output  1  accepted solution available
sol_ready_i  input  1  downstream accepts the solution
sol_data_o  output  VEC_W  accepted solution; equals cand_o while valid
busy_o  output  1  high in any state other than IDLE
done_o  output  1  sticky: the last run produced num_req solutions; cleared by start
fail_o  output  1  sticky: the last run hit MAX_TRIES; cleared by start
tries_o  output  32  total candidates checked in the current or last run; saturates at all-ones

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, lfsr=32'h1, cand_o=0, counters 0, and all outputs 0.
- LFSR: 32-bit right-shift Galois with mask 32'hA3000000 (lsb=1 → (l>>1)^mask, else l>>1). It advances exactly once per FILL cycle and holds otherwise.
- IDLE:
  - start_i=1 → lfsr<=seed (or 1 if the seed is 0), cand<=0, sol_cnt<=0, try_cnt<=0, tries_o<=0, done_o<=0, fail_o<=0, latch num_req.
  - Next state: FILL if num_req≠0. If num_req=0, go straight back to IDLE with done_o<=1.
- FILL (WORDS cycles): each cycle cand <= {cand[VEC_W-33:0], lfsr} (shift left 32, new word in the LSBs, truncate to VEC_W). After WORDS cycles → CHECK.
- CHECK (1 cycle): cand_o is stable and sat_i is sampled at the closing edge. Increment try_cnt and tries_o (tries_o saturates).
  - sat_i=1 → EMIT.
  - else if the incremented try_cnt==MAX_TRIES → IDLE with fail_o<=1.
  - else → FILL.
- EMIT: sol_valid_o=1 and sol_data_o=cand_o.
  - cand_o, sol_data_o and sol_valid_o are held stable until sol_ready_i=1. Valid never drops without a handshake.
  - On handshake: sol_cnt++ and try_cnt<=0. If the new sol_cnt==num_req → IDLE with done_o<=1, otherwise → FILL.
  - sol_valid_o deasserts in the cycle after the handshake.
- Latency:
  - First CHECK occurs WORDS+1 cycles after the start edge; first sol_valid_o occurs at WORDS+2.
  - Steady-state throughput with sat_i=1 and ready=1 is one solution per WORDS+2 cycles.
- start_i outside IDLE is ignored. num_req_i and seed_i changes mid-run have no effect.
- A failure leaves earlier delivered solutions valid. fail_o and done_o are never both 1.
- Reset mid-run aborts immediately: no partial solution is presented afterwards, and done_o/fail_o read 0.
- Identical seed and num_req with an identical sat_i sequence must reproduce the identical cand_o sequence.

Test Plan:
- num_req=0, start pulse → busy_o high for exactly 1 cycle, done_o=1, sol_valid_o never asserted, tries_o=0.
- Run A: VEC_W=185, seed=32'h1, sat_i tied 1, ready tied 1, num_req=3 → valid pulses at cycles 8, 16, 24 after start; done_o=1; tries_o=3. Each sol_data_o matches the reference-model LFSR concatenation.
- sat_i tied 0, MAX_TRIES=4, num_req=2 → fail_o=1 and done_o=0 after 4 CHECKs (cycle 28); tries_o=4; no valid ever.
- Backpressure: sat_i=1, sol_ready_i low for 5 cycles after valid → sol_data_o and cand_o constant and valid held for all 6 cycles; exactly one solution counted.
- Seed 0 vs seed 1 under Run A's conditions → identical sol_data_o sequences. Seed 32'hDEADBEEF → a different first word.
- rst_n pulsed low during EMIT while ready is low → outputs 0 immediately and state IDLE; a new start with the same seed replays Run A's first solution.
